// File: rtl/bp_pkg.sv
// Shared types and helpers for the 2-bit saturating-counter branch predictor.
package bp_pkg;

    typedef logic [1:0] bp_ctr_t;

    localparam bp_ctr_t SNT = 2'd0;
    localparam bp_ctr_t WNT = 2'd1;
    localparam bp_ctr_t WT  = 2'd2;
    localparam bp_ctr_t ST  = 2'd3;

    localparam bp_ctr_t BP_CTR_RST = WNT;

    // Word-aligned PC bits [idx_w+1:2], returned zero-extended; the caller narrows to idx_w.
    function automatic logic [31:0] bp_index(input logic [31:0] pc, input int unsigned idx_w);
        return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
    endfunction

endpackage

// File: rtl/sat_ctr2.sv
// Next-state logic for one 2-bit saturating direction counter.
module sat_ctr2
    import bp_pkg::*;
(
    input  bp_ctr_t ctr,
    input  logic    taken,
    output bp_ctr_t ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != ST) ctr_next = bp_ctr_t'(ctr + 2'd1);
        end else begin
            if (ctr != SNT) ctr_next = bp_ctr_t'(ctr - 2'd1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch-direction predictor: untagged table of 2-bit counters,
// registered fetch-side lookup, execute-side training, mispredict flag and statistics.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    input  logic        id_stall,
    input  logic        id_flush,
    output logic        pred_valid,
    output logic        pred_taken,
    output logic [31:0] pred_pc,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic        ex_pred_taken,
    output logic        mispredict,
    input  logic        stats_clr,
    output logic [31:0] br_count,
    output logic [31:0] mp_count
);

    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] upd_idx;
    logic             upd;
    bp_ctr_t          ctr_q [ENTRIES];
    bp_ctr_t          upd_next;

    assign fetch_idx  = IDX_W'(bp_index(if_pc, IDX_W));
    assign upd_idx    = IDX_W'(bp_index(ex_pc, IDX_W));
    assign upd        = ex_valid & ex_is_branch;
    assign mispredict = upd & (ex_taken ^ ex_pred_taken);

    sat_ctr2 u_sat_ctr2 (
        .ctr      (ctr_q[upd_idx]),
        .taken    (ex_taken),
        .ctr_next (upd_next)
    );

    // Flops, not RAM: every entry must return to WNT on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= BP_CTR_RST;
        end else if (upd) begin
            ctr_q[upd_idx] <= upd_next;
        end
    end

    // Decode-side register: flush beats stall; stall holds; otherwise load the
    // fetch lookup. The lookup reads the table before this edge's update lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_pc    <= 32'd0;
        end else if (id_flush) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
        end else if (!id_stall) begin
            pred_valid <= if_valid;
            pred_taken <= if_valid & ctr_q[fetch_idx][1];
            pred_pc    <= if_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count <= 32'd0;
            mp_count <= 32'd0;
        end else if (stats_clr) begin
            br_count <= 32'd0;
            mp_count <= 32'd0;
        end else if (upd) begin
            if (br_count != 32'hFFFF_FFFF) br_count <= br_count + 32'd1;
            if (mispredict && (mp_count != 32'hFFFF_FFFF)) mp_count <= mp_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus a randomized run
// against a behavioural table/statistics model.
module tb_branch_predictor;

    localparam int ENTRIES = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_valid, id_stall, id_flush;
    logic [31:0] if_pc;
    logic        pred_valid, pred_taken;
    logic [31:0] pred_pc;
    logic        ex_valid, ex_is_branch, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc;
    logic        mispredict;
    logic        stats_clr;
    logic [31:0] br_count, mp_count;

    int n_vec = 0;
    int n_err = 0;

    int          m_ctr [ENTRIES];
    logic        m_pv, m_pt;
    logic [31:0] m_pc;
    bit          m_pc_known;
    logic [31:0] m_br, m_mp;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(ENTRIES)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .id_stall      (id_stall),
        .id_flush      (id_flush),
        .pred_valid    (pred_valid),
        .pred_taken    (pred_taken),
        .pred_pc       (pred_pc),
        .ex_valid      (ex_valid),
        .ex_is_branch  (ex_is_branch),
        .ex_pc         (ex_pc),
        .ex_taken      (ex_taken),
        .ex_pred_taken (ex_pred_taken),
        .mispredict    (mispredict),
        .stats_clr     (stats_clr),
        .br_count      (br_count),
        .mp_count      (mp_count)
    );

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) m_ctr[i] = 1;
        m_pv = 1'b0; m_pt = 1'b0; m_pc = 32'd0; m_pc_known = 1'b1;
        m_br = 32'd0; m_mp = 32'd0;
    endtask

    task automatic idle();
        if_valid = 1'b0; if_pc = 32'd0; id_stall = 1'b0; id_flush = 1'b0;
        ex_valid = 1'b0; ex_is_branch = 1'b0; ex_pc = 32'd0;
        ex_taken = 1'b0; ex_pred_taken = 1'b0; stats_clr = 1'b0;
    endtask

    // Advance one clock edge and let the model absorb the inputs present at that edge.
    task automatic step();
        int fi, ui;
        @(posedge clk);
        fi = int'((if_pc / 4) % ENTRIES);
        if (id_flush) begin
            m_pv = 1'b0; m_pt = 1'b0; m_pc_known = 1'b0;
        end else if (!id_stall) begin
            m_pv = if_valid;
            m_pt = if_valid && (m_ctr[fi] >= 2);
            m_pc = if_pc; m_pc_known = 1'b1;
        end
        if (stats_clr) begin
            m_br = 32'd0; m_mp = 32'd0;
        end else if (ex_valid && ex_is_branch) begin
            if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
            if (ex_taken != ex_pred_taken && m_mp != 32'hFFFF_FFFF) m_mp = m_mp + 1;
        end
        if (ex_valid && ex_is_branch) begin
            ui = int'((ex_pc / 4) % ENTRIES);
            if (ex_taken) m_ctr[ui] = (m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1;
            else          m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
        end
        #1;
    endtask

    task automatic test_reset();
        idle();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (pred_valid !== 1'b0) begin n_err++; $display("FAIL rst_pred_valid: got %0b exp 0", pred_valid); end
        n_vec++; if (pred_pc !== 32'd0) begin n_err++; $display("FAIL rst_pred_pc: got %h exp 0", pred_pc); end
        rst_n = 1'b1;
        if_valid = 1'b1; if_pc = 32'h100;
        step();
        n_vec++; if (pred_valid !== 1'b1) begin n_err++; $display("FAIL rst_lookup_valid: got %0b exp 1", pred_valid); end
        n_vec++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL rst_lookup_taken: got %0b exp 0", pred_taken); end
        n_vec++; if (pred_pc !== 32'h100) begin n_err++; $display("FAIL rst_lookup_pc: got %h exp 100", pred_pc); end
        n_vec++; if (br_count !== 32'd0 || mp_count !== 32'd0) begin
            n_err++; $display("FAIL rst_stats: got br=%0d mp=%0d exp 0/0", br_count, mp_count); end
    endtask

    task automatic test_training();
        idle();
        ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = 32'h100; ex_taken = 1'b1; ex_pred_taken = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_vec++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL train_mispredict%0d: got %0b exp 1", i, mispredict); end
            step();
        end
        idle();
        if_valid = 1'b1; if_pc = 32'h100;
        step();
        n_vec++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL train_pred: got %0b exp 1", pred_taken); end
        n_vec++; if (br_count !== 32'd2) begin n_err++; $display("FAIL train_br: got %0d exp 2", br_count); end
        n_vec++; if (mp_count !== 32'd2) begin n_err++; $display("FAIL train_mp: got %0d exp 2", mp_count); end
    endtask

    task automatic test_saturation();
        idle();
        ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = 32'h100; ex_taken = 1'b0; ex_pred_taken = 1'b0;
        #1;
        n_vec++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL sat_no_mispredict: got %0b exp 0", mispredict); end
        repeat (5) step();
        idle();
        if_valid = 1'b1; if_pc = 32'h100;
        step();
        n_vec++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL sat_low_pred: got %0b exp 0", pred_taken); end
        idle();
        ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = 32'h100; ex_taken = 1'b1;
        step();
        idle();
        if_valid = 1'b1; if_pc = 32'h100;
        step();
        n_vec++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL sat_recover_pred: got %0b exp 0", pred_taken); end
    endtask

    task automatic test_collision();
        idle();
        if_valid = 1'b1; if_pc = 32'h200;
        ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = 32'h200; ex_taken = 1'b1; ex_pred_taken = 1'b1;
        step();
        n_vec++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL coll_same_cycle: got %0b exp 0", pred_taken); end
        idle();
        if_valid = 1'b1; if_pc = 32'h200;
        step();
        n_vec++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL coll_next_cycle: got %0b exp 1", pred_taken); end
    endtask

    task automatic test_stall_flush();
        idle();
        if_valid = 1'b1; if_pc = 32'h300;
        step();
        id_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if_pc = 32'h304 + 32'(i * 4);
            if_valid = i[0];
            step();
            n_vec++; if (pred_pc !== 32'h300 || pred_valid !== 1'b1 || pred_taken !== 1'b1) begin
                n_err++; $display("FAIL stall_hold%0d: got pc=%h v=%0b t=%0b exp pc=300 v=1 t=1", i, pred_pc, pred_valid, pred_taken); end
        end
        id_flush = 1'b1; if_valid = 1'b1;
        step();
        n_vec++; if (pred_valid !== 1'b0 || pred_taken !== 1'b0) begin
            n_err++; $display("FAIL flush_over_stall: got v=%0b t=%0b exp 0/0", pred_valid, pred_taken); end
    endtask

    task automatic test_non_branch();
        logic [31:0] br_before;
        idle();
        br_before = m_br;
        ex_valid = 1'b1; ex_is_branch = 1'b0; ex_pc = 32'h100; ex_taken = 1'b0; ex_pred_taken = 1'b1;
        #1;
        n_vec++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL nonbr_mispredict: got %0b exp 0", mispredict); end
        step();
        idle();
        if_valid = 1'b1; if_pc = 32'h100;
        step();
        n_vec++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL nonbr_ctr_hold: got %0b exp 1", pred_taken); end
        n_vec++; if (br_count !== br_before) begin n_err++; $display("FAIL nonbr_br_hold: got %0d exp %0d", br_count, br_before); end
    endtask

    task automatic test_random();
        logic exp_mp;
        logic [31:0] exp_pc;
        for (int n = 0; n < 400; n++) begin
            if_valid      = 1'($urandom_range(0, 1));
            if_pc         = 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3)) * 256;
            id_stall      = ($urandom_range(0, 7) == 0);
            id_flush      = ($urandom_range(0, 9) == 0);
            ex_valid      = ($urandom_range(0, 3) != 0);
            ex_is_branch  = ($urandom_range(0, 4) != 0);
            ex_pc         = 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3)) * 256;
            ex_taken      = 1'($urandom_range(0, 1));
            ex_pred_taken = 1'($urandom_range(0, 1));
            stats_clr     = ($urandom_range(0, 63) == 0);
            exp_mp = ex_valid && ex_is_branch && (ex_taken != ex_pred_taken);
            #1;
            n_vec++; if (mispredict !== exp_mp) begin n_err++; $display("FAIL rand_mispredict@%0d: got %0b exp %0b", n, mispredict, exp_mp); end
            step();
            n_vec++; if (pred_valid !== m_pv || pred_taken !== m_pt) begin
                n_err++; $display("FAIL rand_pred@%0d: got v=%0b t=%0b exp v=%0b t=%0b", n, pred_valid, pred_taken, m_pv, m_pt); end
            if (m_pc_known) begin
                exp_q.push_back(m_pc);
                exp_pc = exp_q.pop_front();
                n_vec++; if (pred_pc !== exp_pc) begin n_err++; $display("FAIL rand_pc@%0d: got %h exp %h", n, pred_pc, exp_pc); end
            end
            n_vec++; if (br_count !== m_br || mp_count !== m_mp) begin
                n_err++; $display("FAIL rand_stats@%0d: got br=%0d mp=%0d exp br=%0d mp=%0d", n, br_count, mp_count, m_br, m_mp); end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = 32'h104; ex_taken = 1'b1;
        repeat (3) step();
        if_valid = 1'b1; if_pc = 32'h104;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_vec++; if (pred_valid !== 1'b0 || br_count !== 32'd0 || mp_count !== 32'd0) begin
            n_err++; $display("FAIL midrst_async: got v=%0b br=%0d mp=%0d exp 0/0/0", pred_valid, br_count, mp_count); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        if_valid = 1'b1; if_pc = 32'h104;
        step();
        n_vec++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL midrst_trained_cleared: got %0b exp 0", pred_taken); end
        for (int i = 0; i < 4; i++) begin
            idle();
            ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = 32'(i * 4); ex_taken = 1'b1; ex_pred_taken = 1'b1;
            step();
            idle();
            if_valid = 1'b1; if_pc = 32'(i * 4);
            step();
            n_vec++; if (pred_taken !== ((m_ctr[i] >= 2) ? 1'b1 : 1'b0)) begin
                n_err++; $display("FAIL midrst_wnt%0d: got %0b exp %0b", i, pred_taken, (m_ctr[i] >= 2)); end
        end
    endtask

    task automatic test_stats();
        idle();
        force dut.br_count = 32'hFFFF_FFFE;
        force dut.mp_count = 32'hFFFF_FFFF;
        #1;
        release dut.br_count;
        release dut.mp_count;
        m_br = 32'hFFFF_FFFE; m_mp = 32'hFFFF_FFFF;
        ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = 32'h10; ex_taken = 1'b1; ex_pred_taken = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_vec++; if (br_count !== 32'hFFFF_FFFF || mp_count !== 32'hFFFF_FFFF) begin
                n_err++; $display("FAIL stats_sat%0d: got br=%h mp=%h exp ffffffff/ffffffff", i, br_count, mp_count); end
        end
        stats_clr = 1'b1;
        step();
        n_vec++; if (br_count !== 32'd0 || mp_count !== 32'd0) begin
            n_err++; $display("FAIL stats_clr_prio: got br=%0d mp=%0d exp 0/0", br_count, mp_count); end
        stats_clr = 1'b0;
        step();
        n_vec++; if (br_count !== 32'd1 || mp_count !== 32'd1) begin
            n_err++; $display("FAIL stats_after_clr: got br=%0d mp=%0d exp 1/1", br_count, mp_count); end
        idle();
    endtask

    initial begin
        test_reset();
        test_training();
        test_saturation();
        test_collision();
        test_stall_flush();
        test_non_branch();
        test_random();
        test_reset_mid();
        test_stats();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
